// File: rtl/tt_um_cod_hex7seg_pkg.sv
// ---------------------------------------------------------------------------
// tt_um_cod_hex7seg_pkg
//   Shared constants and helpers for the dual-digit hex 7-segment decoder.
//   SEG_LUT     : 16 x 7-bit segment codes {g,f,e,d,c,b,a}, active-high,
//                 indexed by nibble value
//   SEG_OFF     : all segments dark
//   letter_flag : 1 when the nibble is a letter digit (A..F)
// ---------------------------------------------------------------------------
package tt_um_cod_hex7seg_pkg;

    // Packed with entry 15 at the MSB end, so SEG_LUT[n] is the code for n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic letter_flag(input logic [3:0] nibble);
        return (nibble >= 4'hA);
    endfunction

endpackage

// File: rtl/tt_um_cod_hex7seg_decoder.sv
// ---------------------------------------------------------------------------
// hex7seg_decoder
//   Purely combinational nibble to 7-segment decoder, active-high.
//   Ports:
//     nib_i [3:0] : nibble value
//     out_o [7:0] : {letter flag, segments g..a}
// ---------------------------------------------------------------------------
module hex7seg_decoder
    import tt_um_cod_hex7seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] out_o
);

    always_comb begin
        out_o = {letter_flag(nib_i), SEG_LUT[nib_i]};
    end

endmodule

// File: rtl/tt_um_cod_hex7seg.sv
// ---------------------------------------------------------------------------
// tt_um_cod_hex7seg
//   Dual-digit binary-to-hex 7-segment decoder in the TinyTapeout wrapper.
//   Outputs are registered; one clock of latency from ui_in.
//   Ports:
//     clk     : clock, rising edge
//     rst_n   : synchronous active-low reset (outputs dark), beats ena
//     ena     : 1 = load new digits, 0 = hold outputs
//     ui_in   : [3:0] low digit, [7:4] high digit
//     uo_out  : low digit  {flag, g..a}
//     uio_in  : ignored
//     uio_out : high digit {flag, g..a}
//     uio_oe  : constant 8'hFF
//   Configuration macro COMMON_ANODE_EN: when defined, all bits of uo_out
//   and uio_out are inverted (reset value becomes 8'hFF).
// ---------------------------------------------------------------------------
module tt_um_cod_hex7seg
    import tt_um_cod_hex7seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

`ifdef COMMON_ANODE_EN
    localparam logic [7:0] POL_MASK = '1;
`else
    localparam logic [7:0] POL_MASK = '0;
`endif

    localparam logic [7:0] DARK = {1'b0, SEG_OFF} ^ POL_MASK;

    logic [7:0] dec_lo;
    logic [7:0] dec_hi;
    logic [7:0] lo_d, lo_q;
    logic [7:0] hi_d, hi_q;

    // uio_in has no function; reduced into a sink so it is not left dangling.
    logic       unused_uio;
    assign unused_uio = &{1'b0, uio_in};

    hex7seg_decoder u_dec_lo (
        .nib_i (ui_in[3:0]),
        .out_o (dec_lo)
    );

    hex7seg_decoder u_dec_hi (
        .nib_i (ui_in[7:4]),
        .out_o (dec_hi)
    );

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (ena) begin
            lo_d = dec_lo ^ POL_MASK;
            hi_d = dec_hi ^ POL_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo_q <= DARK;
            hi_q <= DARK;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign uo_out  = lo_q;
    assign uio_out = hi_q;
    assign uio_oe  = '1;

endmodule

// File: tb/tb_tt_um_cod_hex7seg.sv
module tb_tt_um_cod_hex7seg;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned n_checks;
    int unsigned n_pass;

    logic [15:0] sb_q[$];
    logic [7:0]  exp_lo;
    logic [7:0]  exp_hi;

`ifdef COMMON_ANODE_EN
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] INV = 8'h00;
`endif

    localparam logic [6:0] REF_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    tt_um_cod_hex7seg dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_digit(input logic [3:0] n);
        return {(n > 4'd9), REF_SEG[n]} ^ INV;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    // Drive one cycle of stimulus, predict the registered result, then
    // compare it against the DUT just after the edge.
    task automatic step(input string tag, input logic r, input logic e, input logic [7:0] u);
        logic [15:0] pair;
        rst_n = r;
        ena   = e;
        ui_in = u;
        if (!r) begin
            exp_lo = 8'h00 ^ INV;
            exp_hi = 8'h00 ^ INV;
        end else if (e) begin
            exp_lo = ref_digit(u[3:0]);
            exp_hi = ref_digit(u[7:4]);
        end
        sb_q.push_back({exp_hi, exp_lo});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 8'h00, 8'h01);
        end else begin
            pair = sb_q.pop_front();
            check({tag, "_lo"}, uo_out, pair[7:0]);
            check({tag, "_hi"}, uio_out, pair[15:8]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_lo   = 8'h00;
        exp_hi   = 8'h00;
        rst_n    = 1'b0;
        ena      = 1'b1;
        ui_in    = 8'hFF;
        uio_in   = 8'h5A;

        step("rst1", 1'b0, 1'b1, 8'hFF);
        step("rst2", 1'b0, 1'b0, 8'hFF);
        check("oe_rst", uio_oe, 8'hFF);

        step("zero", 1'b1, 1'b1, 8'h00);
        step("a5",   1'b1, 1'b1, 8'hA5);
        step("f8",   1'b1, 1'b1, 8'hF8);
        step("zero2", 1'b1, 1'b1, 8'h00);

        // outputs must not follow ui_in before a clock edge
        ui_in = 8'h77;
        #1;
        check("nocomb_lo", uo_out, exp_lo);
        check("nocomb_hi", uio_out, exp_hi);

        for (int i = 0; i < 3; i++) step("hold", 1'b1, 1'b0, 8'hEE);
        step("ena_back", 1'b1, 1'b1, 8'hEE);

        step("midrst", 1'b0, 1'b1, 8'h12);
        step("release", 1'b1, 1'b1, 8'h34);
        step("rst_ena0", 1'b0, 1'b0, 8'h9C);
        step("hold_dark", 1'b1, 1'b0, 8'hB6);
        check("oe_run", uio_oe, 8'hFF);

        for (int v = 0; v < 256; v++) step("sweep", 1'b1, 1'b1, 8'(v));

        for (int k = 0; k < 40; k++)
            step("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                 8'($urandom_range(0, 255)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
